ppu_vmem_arb: RTL and testbench

// - Parametrised PPU video-memory controller: arbitrates NUM_CH requestors onto one vidmem bus
//   (e.g. ch0 bg fetch, ch1 sprite fetch, ch2 CPU register interface).
// - Owns the internal palette RAM, palette mirroring and nametable mirroring.
// - Exposes a dedicated render palette read port for the VGA path.

---
 rtl/ppu_pkg.sv | 20 ++
 rtl/ppu_rr_arb.sv | 47 ++++
 rtl/ppu_vmem_arb.sv | 134 +++++++++++++
 tb/tb_ppu_vmem_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU constants: mirroring modes, address-map fields and the palette alias rule.
package ppu_pkg;

   localparam logic [1:0] MIR_HORIZ   = 2'd0;
   localparam logic [1:0] MIR_VERT    = 2'd1;
   localparam logic [1:0] MIR_SNGL_LO = 2'd2;
   localparam logic [1:0] MIR_SNGL_HI = 2'd3;

   localparam logic [5:0] PAL_PAGE = 6'h3F;
   localparam logic [1:0] NT_BASE  = 2'b10;

   // Backdrop entries 0x10/14/18/1C share storage with 0x00/04/08/0C.
   function automatic logic [4:0] pal_alias(input logic [4:0] idx, input logic [4:0] mask);
      logic [4:0] p;
      p = idx & mask;
      if (p[4] && (p[1:0] == 2'b00)) p[4] = 1'b0;
      return p;
   endfunction

endpackage

// File: rtl/ppu_rr_arb.sv
// Round-robin arbiter over ch1..NUM_CH-1 with an absolute-priority override on ch0.
module ppu_rr_arb #(
   parameter int NUM_CH = 3,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [NUM_CH-1:0] req_in,
   output logic [NUM_CH-1:0] gnt_out,
   output logic [CH_W-1:0]   win_out
);

   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [CH_W:0]   idx;
   logic            found;

   always_comb begin
      gnt_out = '0;
      win_out = '0;
      ptr_d   = ptr_q;
      idx     = '0;
      found   = 1'b0;
      if (rst_n_in) begin
         if (req_in[0]) begin
            gnt_out[0] = 1'b1;
         end else begin
            // Walk ch1..NUM_CH-1 starting at the pointer, wrapping past ch0.
            for (int i = 0; i < NUM_CH - 1; i++) begin
               idx = {1'b0, ptr_q} + (CH_W+1)'(i);
               if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH - 1);
               if (!found && req_in[idx[CH_W-1:0]]) begin
                  found                   = 1'b1;
                  gnt_out[idx[CH_W-1:0]]  = 1'b1;
                  win_out                 = idx[CH_W-1:0];
                  ptr_d = (idx == (CH_W+1)'(NUM_CH - 1)) ? CH_W'(1) : idx[CH_W-1:0] + CH_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) ptr_q <= CH_W'(1);
      else           ptr_q <= ptr_d;
   end

endmodule

// File: rtl/ppu_vmem_arb.sv
// PPU video-memory controller: arbitration, address mirroring, palette RAM and a
// two-stage access pipeline, plus an independent render palette read port.
module ppu_vmem_arb
   import ppu_pkg::*;
#(
   parameter int NUM_CH    = 3,
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 8,
   parameter int PAL_DEPTH = 32,
   parameter int PAL_W     = 6
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic [1:0]               mirror_in,
   input  logic [NUM_CH-1:0]        req_in,
   input  logic [NUM_CH-1:0]        wr_in,
   input  logic [NUM_CH*ADDR_W-1:0] a_in,
   input  logic [NUM_CH*DATA_W-1:0] d_in,
   output logic [NUM_CH-1:0]        gnt_out,
   output logic [NUM_CH-1:0]        rvalid_out,
   output logic [DATA_W-1:0]        rd_out,
   input  logic [DATA_W-1:0]        vram_d_in,
   output logic [ADDR_W-1:0]        vram_a_out,
   output logic [DATA_W-1:0]        vram_d_out,
   output logic                     vram_wr_out,
   input  logic [4:0]               pal_idx_in,
   output logic [PAL_W-1:0]         pal_q_out
);

   localparam int         CH_W     = $clog2(NUM_CH);
   localparam int         PAL_AW   = $clog2(PAL_DEPTH);
   localparam logic [4:0] PAL_MASK = 5'(PAL_DEPTH - 1);

   logic [ADDR_W-1:0] a_ch [NUM_CH];
   logic [DATA_W-1:0] d_ch [NUM_CH];
   logic [CH_W-1:0]   win;
   logic [ADDR_W-1:0] a_sel, a_map;
   logic [DATA_W-1:0] d_sel;
   logic              wr_sel, any_gnt, is_pal, pal_we;
   logic [PAL_AW-1:0] pal_idx, rnd_idx;

   logic [PAL_W-1:0]  pal_mem [PAL_DEPTH];

   logic [ADDR_W-1:0] vram_a_q;
   logic [DATA_W-1:0] vram_d_q;
   logic              vram_wr_q;
   logic [PAL_W-1:0]  pal_q_q;
   logic              s1_vld_q, s2_vld_q, s1_pal_q, s2_pal_q;
   logic [CH_W-1:0]   s1_ch_q, s2_ch_q;
   logic [PAL_W-1:0]  s1_pdat_q, s2_pdat_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign a_ch[gi]       = a_in[gi*ADDR_W +: ADDR_W];
         assign d_ch[gi]       = d_in[gi*DATA_W +: DATA_W];
         assign rvalid_out[gi] = s2_vld_q && (s2_ch_q == CH_W'(gi));
      end
   endgenerate

   ppu_rr_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .req_in   (req_in),
      .gnt_out  (gnt_out),
      .win_out  (win)
   );

   always_comb begin
      a_sel   = a_ch[win];
      d_sel   = d_ch[win];
      wr_sel  = wr_in[win];
      any_gnt = |gnt_out;
      is_pal  = (a_sel[13:8] == PAL_PAGE);
      a_map   = a_sel;
      if (!is_pal && (a_map[13:12] == 2'b11)) a_map = a_map & ADDR_W'(14'h2FFF);
      if (a_map[13:12] == NT_BASE) begin
         case (mirror_in)
            MIR_HORIZ: begin
               a_map[10] = a_map[11];
               a_map[11] = 1'b0;
            end
            MIR_VERT:    a_map[11]    = 1'b0;
            MIR_SNGL_LO: a_map[11:10] = 2'b00;
            default:     a_map[11:10] = 2'b01;
         endcase
      end
      pal_idx = PAL_AW'(pal_alias(a_sel[4:0], PAL_MASK));
      rnd_idx = PAL_AW'(pal_alias(pal_idx_in, PAL_MASK));
      pal_we  = any_gnt && wr_sel && is_pal;
   end

   // Palette storage is deliberately left out of reset.
   always_ff @(posedge clk_in) begin
      if (pal_we) pal_mem[pal_idx] <= d_sel[PAL_W-1:0];
      s1_pdat_q <= pal_mem[pal_idx];
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         vram_a_q  <= '0;
         vram_d_q  <= '0;
         vram_wr_q <= 1'b0;
         pal_q_q   <= '0;
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         s1_pal_q  <= 1'b0;
         s2_pal_q  <= 1'b0;
         s1_ch_q   <= '0;
         s2_ch_q   <= '0;
         s2_pdat_q <= '0;
      end else begin
         vram_wr_q <= any_gnt && wr_sel && !is_pal;
         if (any_gnt) vram_a_q <= a_map;
         if (any_gnt && wr_sel && !is_pal) vram_d_q <= d_sel;
         pal_q_q   <= pal_mem[rnd_idx];
         s1_vld_q  <= any_gnt && !wr_sel;
         s1_pal_q  <= is_pal;
         s1_ch_q   <= win;
         s2_vld_q  <= s1_vld_q;
         s2_pal_q  <= s1_pal_q;
         s2_ch_q   <= s1_ch_q;
         s2_pdat_q <= s1_pdat_q;
      end
   end

   assign vram_a_out  = vram_a_q;
   assign vram_d_out  = vram_d_q;
   assign vram_wr_out = vram_wr_q;
   assign pal_q_out   = pal_q_q;
   // Palette reads substitute their own data for whatever the external bus returns.
   assign rd_out      = !s2_vld_q ? '0 : (s2_pal_q ? DATA_W'(s2_pdat_q) : vram_d_in);

endmodule

// File: tb/tb_ppu_vmem_arb.sv
// Directed bench for ppu_vmem_arb: reset, arbitration, mirroring, palette and pipeline timing.
module tb_ppu_vmem_arb;

   localparam int NUM_CH = 3;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int PAL_W  = 6;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [1:0]               mirror;
   logic [NUM_CH-1:0]        req, wr, gnt, rvalid;
   logic [NUM_CH*ADDR_W-1:0] a_bus;
   logic [NUM_CH*DATA_W-1:0] d_bus;
   logic [DATA_W-1:0]        rd, vram_d_i, vram_d_o;
   logic [ADDR_W-1:0]        vram_a;
   logic                     vram_wr;
   logic [4:0]               pal_idx;
   logic [PAL_W-1:0]         pal_q;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ppu_vmem_arb dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .mirror_in   (mirror),
      .req_in      (req),
      .wr_in       (wr),
      .a_in        (a_bus),
      .d_in        (d_bus),
      .gnt_out     (gnt),
      .rvalid_out  (rvalid),
      .rd_out      (rd),
      .vram_d_in   (vram_d_i),
      .vram_a_out  (vram_a),
      .vram_d_out  (vram_d_o),
      .vram_wr_out (vram_wr),
      .pal_idx_in  (pal_idx),
      .pal_q_out   (pal_q)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle access on a single channel; returns at N+1 with the request dropped.
   task automatic acc(input int ch, input logic w, input logic [13:0] addr,
                      input logic [7:0] data, input string tag);
      req                          = '0;
      req[ch]                      = 1'b1;
      wr[ch]                       = w;
      a_bus[ch*ADDR_W +: ADDR_W]   = addr;
      d_bus[ch*DATA_W +: DATA_W]   = data;
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(gnt), 32'(1 << ch));
      tick();
      req = '0;
      $display("acc %s ch%0d %s a=%h d=%h", tag, ch, w ? "wr" : "rd", addr, data);
   endtask

   typedef struct packed {
      logic [1:0]  mir;
      logic [13:0] a;
      logic [13:0] exp;
   } mvec_t;

   mvec_t mt [10] = '{
      '{2'd0, 14'h2C05, 14'h2405},
      '{2'd1, 14'h2C05, 14'h2405},
      '{2'd2, 14'h2C05, 14'h2005},
      '{2'd3, 14'h2C05, 14'h2405},
      '{2'd1, 14'h2805, 14'h2005},
      '{2'd0, 14'h2805, 14'h2405},
      '{2'd1, 14'h3405, 14'h2405},
      '{2'd0, 14'h3405, 14'h2005},
      '{2'd0, 14'h0123, 14'h0123},
      '{2'd3, 14'h3C05, 14'h2405}
   };

   logic [2:0] rr_exp [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

   initial begin
      rst_n    = 1'b0;
      req      = 3'b111;
      wr       = '0;
      a_bus    = '0;
      d_bus    = '0;
      mirror   = 2'd0;
      vram_d_i = '0;
      pal_idx  = '0;

      // Reset held 3 clocks with all channels requesting
      repeat (3) begin
         @(negedge clk);
         chk("rst_gnt", 32'(gnt), 32'h0);
      end
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rd", 32'(rd), 32'h0);
      chk("rst_vram_a", 32'(vram_a), 32'h0);
      chk("rst_vram_d", 32'(vram_d_o), 32'h0);
      chk("rst_vram_wr", 32'(vram_wr), 32'h0);
      chk("rst_pal_q", 32'(pal_q), 32'h0);
      tick();
      rst_n = 1'b1;
      req   = '0;
      tick();

      // Round-robin between ch1/ch2, then ch0 override
      req = 3'b110;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
         $display("rr cycle %0d gnt=%b", i, gnt);
         tick();
      end
      req = 3'b111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ch0_prio_gnt", 32'(gnt), 32'h1);
         tick();
      end
      req = 3'b110;
      @(negedge clk);
      chk("rr_ptr_kept", 32'(gnt), 32'h2);
      tick();
      req = '0;
      repeat (3) tick();

      // Nametable mirroring and fold
      for (int i = 0; i < 10; i++) begin
         mirror = mt[i].mir;
         acc(2, 1'b0, mt[i].a, 8'h00, "mir");
         chk("mir_vram_a", 32'(vram_a), 32'(mt[i].exp));
         chk("mir_vram_wr", 32'(vram_wr), 32'h0);
      end
      repeat (3) tick();

      // External write path
      mirror = 2'd1;
      acc(2, 1'b1, 14'h2C05, 8'h5A, "ntwr");
      chk("ntwr_vram_wr", 32'(vram_wr), 32'h1);
      chk("ntwr_vram_d", 32'(vram_d_o), 32'h5A);
      chk("ntwr_vram_a", 32'(vram_a), 32'h2405);
      tick();
      chk("ntwr_wr_drop", 32'(vram_wr), 32'h0);
      chk("ntwr_a_hold", 32'(vram_a), 32'h2405);
      chk("ntwr_no_rvalid", 32'(rvalid), 32'h0);
      repeat (2) tick();

      // Palette aliasing via the arbitrated port
      acc(2, 1'b1, 14'h3F10, 8'hFF, "palwr");
      chk("palwr_vram_wr", 32'(vram_wr), 32'h0);
      chk("palwr_vram_a", 32'(vram_a), 32'h3F10);
      acc(1, 1'b1, 14'h3F04, 8'h2A, "palwr4");
      chk("palwr4_vram_wr", 32'(vram_wr), 32'h0);
      vram_d_i = 8'hEE;
      acc(2, 1'b0, 14'h3F00, 8'h00, "palrd");
      chk("palrd_vram_wr", 32'(vram_wr), 32'h0);
      tick();
      chk("palrd_rvalid", 32'(rvalid), 32'h4);
      chk("palrd_rd", 32'(rd), 32'h3F);
      vram_d_i = 8'h00;

      // Render port aliasing and read-first behaviour
      pal_idx = 5'h10;
      tick();
      chk("rnd_10", 32'(pal_q), 32'h3F);
      pal_idx = 5'h14;
      tick();
      chk("rnd_14", 32'(pal_q), 32'h2A);
      pal_idx = 5'h00;
      acc(2, 1'b1, 14'h3F00, 8'h07, "palrf");
      chk("rnd_readfirst", 32'(pal_q), 32'h3F);
      tick();
      chk("rnd_newdata", 32'(pal_q), 32'h07);
      repeat (3) tick();

      // Latency and back-to-back reads on ch1
      req                        = 3'b010;
      wr                         = '0;
      a_bus[1*ADDR_W +: ADDR_W]  = 14'h0123;
      @(negedge clk);
      chk("b2b_gnt0", 32'(gnt), 32'h2);
      tick();
      a_bus[1*ADDR_W +: ADDR_W]  = 14'h0124;
      chk("b2b_vram_a0", 32'(vram_a), 32'h0123);
      chk("b2b_early", 32'(rvalid), 32'h0);
      @(negedge clk);
      chk("b2b_gnt1", 32'(gnt), 32'h2);
      tick();
      req      = '0;
      vram_d_i = 8'hA1;
      chk("b2b_vram_a1", 32'(vram_a), 32'h0124);
      @(negedge clk);
      chk("b2b_rvalid0", 32'(rvalid), 32'h2);
      chk("b2b_rd0", 32'(rd), 32'hA1);
      tick();
      vram_d_i = 8'hA2;
      @(negedge clk);
      chk("b2b_rvalid1", 32'(rvalid), 32'h2);
      chk("b2b_rd1", 32'(rd), 32'hA2);
      tick();
      vram_d_i = 8'h00;
      chk("b2b_done", 32'(rvalid), 32'h0);
      repeat (2) tick();

      // Reset mid-flight: read on ch1 leaves pointer at ch2, reset must restore ch1
      acc(1, 1'b0, 14'h0200, 8'h00, "flight");
      rst_n = 1'b0;
      req   = 3'b110;
      @(negedge clk);
      chk("flight_rst_gnt", 32'(gnt), 32'h0);
      tick();
      rst_n = 1'b1;
      req   = '0;
      chk("flight_rvalid_n2", 32'(rvalid), 32'h0);
      chk("flight_vram_a", 32'(vram_a), 32'h0);
      tick();
      chk("flight_rvalid_n3", 32'(rvalid), 32'h0);
      req = 3'b110;
      @(negedge clk);
      chk("flight_ptr_ch1", 32'(gnt), 32'h2);
      tick();
      req = '0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
